// File: rtl/fib_req_scheduler.sv
// rtl/fib_req_scheduler.sv - round-robin arbitrated Fibonacci request scheduler
// One requester is served at a time; F(n) is built iteratively with sticky overflow tracking.
module fib_req_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 32,
  parameter int NW   = 6,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*NW-1:0]   req_n,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [W-1:0]         rsp_fib,
  output logic                 rsp_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic            rsp_valid_q;
  logic [IW-1:0]   rsp_id_q;
  logic [W-1:0]    rsp_fib_q;
  logic            rsp_ovf_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            ovf_a_q;
  logic            ovf_b_q;
  logic [NW-1:0]   cnt_q;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   ptr_d;
  logic [W:0]      sum_d;

  // Search starts at ptr_q so the most recently served requester has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign sum_d = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_fib_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= W'(1);
      ovf_a_q     <= 1'b0;
      ovf_b_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            gnt_q    <= NREQ'(1) << win_idx;
            rsp_id_q <= win_idx;
            cnt_q    <= req_n[win_idx*NW +: NW];
            a_q      <= '0;
            b_q      <= W'(1);
            ovf_a_q  <= 1'b0;
            ovf_b_q  <= 1'b0;
            ptr_q    <= ptr_d;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (cnt_q != '0) begin
            a_q     <= b_q;
            b_q     <= sum_d[W-1:0];
            ovf_a_q <= ovf_b_q;
            // b runs one term ahead, so its overflow only reaches rsp_ovf if n needs it
            ovf_b_q <= ovf_a_q | ovf_b_q | sum_d[W];
            cnt_q   <= cnt_q - 1'b1;
          end else begin
            rsp_fib_q   <= a_q;
            rsp_ovf_q   <= ovf_a_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_fib   = rsp_fib_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_fib_req_scheduler.sv
// tb/tb_fib_req_scheduler.sv - scoreboard testbench for fib_req_scheduler
module tb_fib_req_scheduler;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int NW   = 6;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*NW-1:0] req_n;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_fib;
  logic              rsp_ovf;

  typedef struct {
    int          id;
    logic [W-1:0] fib;
    logic        ovf;
    int          n;
  } rsp_t;

  int   exp_gnt[$];
  rsp_t exp_rsp[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   mptr = 0;
  int   cyc = 0;
  int   ready_mode = 0;

  fib_req_scheduler #(.NREQ(NREQ), .W(W), .NW(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_n     (req_n),
    .gnt       (gnt),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_fib   (rsp_fib),
    .rsp_ovf   (rsp_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint unsigned fib_true(input int n);
    longint unsigned fa, fb, t;
    fa = 0;
    fb = 1;
    for (int i = 0; i < n; i++) begin
      t  = fa + fb;
      fa = fb;
      fb = t;
    end
    return fa;
  endfunction

  function automatic logic [NW-1:0] rand_n();
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 6))
        0: return NW'(0);
        1: return NW'(1);
        2: return NW'(2);
        3: return NW'(46);
        4: return NW'(47);
        5: return NW'(48);
        default: return NW'(63);
      endcase
    end
    return NW'($urandom_range(0, 24));
  endfunction

  // Reference: round-robin choice from the model pointer, exact F(n) in 64 bits.
  task automatic predict(output int w);
    rsp_t e;
    longint unsigned f;
    int k;
    w = -1;
    for (int i = 0; i < NREQ; i++) begin
      k = (mptr + i) % NREQ;
      if (w < 0 && req[k]) w = k;
    end
    if (w >= 0) begin
      e.n   = int'(req_n[w*NW +: NW]);
      f     = fib_true(e.n);
      e.id  = w;
      e.fib = f[W-1:0];
      e.ovf = (f >> W) != 0;
      exp_gnt.push_back(w);
      exp_rsp.push_back(e);
      mptr = (w + 1) % NREQ;
    end
  endtask

  task automatic wait_gnt();
    int t;
    t = 0;
    do begin
      @(posedge clk); #2;
      t++;
    end while (gnt == '0 && t < 400);
    if (gnt == '0) begin
      n_vec++;
      n_fail++;
      $display("FAIL gnt_timeout: got no grant, expected one within 400 cycles");
    end
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!rsp_valid && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    check("rsp_valid_arrives", rsp_valid, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || rsp_valid || exp_rsp.size() != 0) && t < 600) begin
      @(posedge clk); #2;
      t++;
    end
    check("idle_reached", busy, 0);
    check("rsp_queue_drained", exp_rsp.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_fib"}, rsp_fib, 0);
    check({tag, "_rsp_ovf"}, rsp_ovf, 0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 1) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: samples on the falling edge, compares against the scoreboard queues.
  initial begin
    logic         pv, pr, pg, povf;
    logic [IW-1:0] pid;
    logic [W-1:0] pfib;
    int           gcyc, e;
    rsp_t         r;
    pv = 0; pr = 0; pg = 0; povf = 0; pid = '0; pfib = '0; gcyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pv = 0; pr = 0; pg = 0;
      end else begin
        if (gnt != '0) begin
          check("gnt_one_cycle", pg, 0);
          if (exp_gnt.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL gnt_unexpected: got %b, expected no grant", gnt);
          end else begin
            e = exp_gnt.pop_front();
            check("gnt_winner", gnt, 64'(1) << e);
          end
          gcyc = cyc;
        end
        if (pv && !pr) begin
          check("hold_valid", rsp_valid, 1);
          check("hold_id", rsp_id, pid);
          check("hold_fib", rsp_fib, pfib);
          check("hold_ovf", rsp_ovf, povf);
          check("no_gnt_in_resp", gnt, 0);
        end
        if (rsp_valid) check("busy_in_resp", busy, 1);
        if (rsp_valid && !pv && exp_rsp.size() != 0)
          check("latency", cyc - gcyc, exp_rsp[0].n + 1);
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL rsp_unexpected: got id %0d fib %0d, expected none", rsp_id, rsp_fib);
          end else begin
            r = exp_rsp.pop_front();
            check("rsp_id", rsp_id, r.id);
            check("rsp_fib", rsp_fib, r.fib);
            check("rsp_ovf", rsp_ovf, r.ovf);
          end
        end
        pv = rsp_valid; pr = rsp_ready; pg = (gnt != '0);
        pid = rsp_id; pfib = rsp_fib; povf = rsp_ovf;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    int nl[6];
    logic [NREQ-1:0] ns;
    nl = '{0, 1, 2, 47, 48, 63};
    rst = 1'b1; req = '0; req_n = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;

    req = 4'b0100;
    req_n[2*NW +: NW] = 6'd10;
    predict(w);
    wait_gnt();
    check("gnt_req2", gnt, 4'b0100);
    req = '0;
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      w = $urandom_range(0, NREQ - 1);
      req = '0;
      req[w] = 1'b1;
      req_n[w*NW +: NW] = NW'(nl[i]);
      predict(w);
      wait_gnt();
      req = '0;
      wait_idle();
    end

    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    mptr = 0;
    req = 4'b1111;
    for (int k = 0; k < NREQ; k++) req_n[k*NW +: NW] = NW'($urandom_range(0, 8));
    for (int i = 0; i < 6; i++) begin
      predict(w);
      wait_gnt();
      check("rr_order", gnt, 64'(1) << (i % NREQ));
    end
    req = 4'b1001;
    predict(w);
    wait_gnt();
    check("rr_skip_to_3", gnt, 4'b1000);
    req = '0;
    wait_idle();

    req = 4'b0001;
    req_n[0 +: NW] = 6'd3;
    rsp_ready = 1'b0;
    predict(w);
    wait_gnt();
    predict(w);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("stall_gnt_zero", gnt, 0);
      check("stall_valid", rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    wait_gnt();
    check("gnt_after_stall", gnt, 4'b0001);
    req = '0;
    wait_idle();

    req = 4'b0010;
    req_n[1*NW +: NW] = 6'd20;
    predict(w);
    wait_gnt();
    repeat (3) begin
      @(posedge clk); #2;
    end
    rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    exp_rsp.delete();
    exp_gnt.delete();
    mptr = 0;
    repeat (2) begin
      @(posedge clk); #2;
    end
    rst = 1'b0;
    predict(w);
    wait_gnt();
    check("gnt_after_rst", gnt, 4'b0010);
    req = '0;
    wait_idle();

    ready_mode = 1;
    w = -1;
    for (int it = 0; it < 40; it++) begin
      ns = NREQ'($urandom_range(1, 15));
      for (int k = 0; k < NREQ; k++)
        if (ns[k] && !(req[k] && k != w)) req_n[k*NW +: NW] = rand_n();
      req = ns;
      predict(w);
      wait_gnt();
    end
    req = '0;
    ready_mode = 0;
    rsp_ready = 1'b1;
    wait_idle();
    check("gnt_queue_drained", exp_gnt.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
